// File: rtl/ps2_pkg.sv
// Shared constants and decoder state type for the PS/2 keyboard receiver.
// Covers scan-code prefixes, ignored codes and the snake game key codes.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] PS2_IGN_ERR0   = 8'h00;
    localparam logic [7:0] PS2_IGN_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_IGN_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_IGN_ACK    = 8'hFA;
    localparam logic [7:0] PS2_IGN_RESEND = 8'hFE;
    localparam logic [7:0] PS2_IGN_ERR1   = 8'hFF;

    localparam logic [7:0] KEY_W   = 8'h1D;
    localparam logic [7:0] KEY_S   = 8'h1B;
    localparam logic [7:0] KEY_A   = 8'h1C;
    localparam logic [7:0] KEY_D   = 8'h23;
    localparam logic [7:0] KEY_ESC = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_IGN_ERR0)   || (b == PS2_IGN_BAT_OK) ||
               (b == PS2_IGN_ECHO)   || (b == PS2_IGN_ACK)    ||
               (b == PS2_IGN_RESEND) || (b == PS2_IGN_ERR1);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: synchronizers, clock glitch filter, bit shifter, timeout.
// Macro PS2_PARITY_CHECK_EN enables the odd-parity and stop-bit checks.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 216000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic          r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic [3:0]    r_bitcnt;
    logic [8:0]    r_shift;
    logic [TW-1:0] r_tocnt;
    logic          r_byte_valid;
    logic [7:0]    r_byte_data;

    logic          w_clk_s;
    logic          w_data_s;
    logic          w_fall;
    logic          w_expired;
    logic [3:0]    w_bit_idx;
    logic          w_frame_ok;

    assign w_clk_s   = r_clk_sync[1];
    assign w_data_s  = r_data_sync[1];
    assign w_fall    = r_filt_d & ~r_filt;
    assign w_expired = (r_tocnt == TW'(TIMEOUT_CYCLES));
    // An edge landing on the expiry cycle starts a fresh frame
    assign w_bit_idx = w_expired ? 4'd0 : r_bitcnt;

`ifdef PS2_PARITY_CHECK_EN
    assign w_frame_ok = (^r_shift) & w_data_s;
`else
    assign w_frame_ok = 1'b1;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_filt      <= 1'b1;
            r_filt_d    <= 1'b1;
            r_fcnt      <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_filt_d    <= r_filt;
            if (w_clk_s != r_filt) begin
                if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                    r_filt <= w_clk_s;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_tocnt      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_fall) begin
                r_tocnt <= '0;
                case (w_bit_idx)
                    4'd0:    r_bitcnt <= w_data_s ? 4'd0 : 4'd1;
                    4'd10: begin
                        r_bitcnt     <= '0;
                        r_byte_valid <= w_frame_ok;
                        r_byte_data  <= r_shift[7:0];
                    end
                    default: begin
                        r_shift  <= {w_data_s, r_shift[8:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end
                endcase
            end else begin
                if (w_expired) begin
                    r_bitcnt <= '0;
                end else begin
                    r_tocnt <= r_tocnt + 1'b1;
                end
            end
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard: deframes scan codes and tracks the last pressed key.
// PS2_CLK/PS2_DATA are never driven. Macro PS2_PARITY_CHECK_EN is honoured in ps2_frame_rx.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 216000
) (
    input  logic       CLK,
    input  logic       reset,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA,
    output logic       key_pressed,
    output logic [7:0] key_pressed_code
);
    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_is_prefix;
    logic       w_is_ign;

    ps2_state_t r_state;
    ps2_state_t w_state_nxt;
    logic       r_pressed;
    logic [7:0] r_code;
    logic       w_pressed_nxt;
    logic [7:0] w_code_nxt;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .CLK        (CLK),
        .reset      (reset),
        .i_ps2_clk  (PS2_CLK),
        .i_ps2_data (PS2_DATA),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data)
    );

    assign w_is_ign    = is_ignored(w_byte_data);
    assign w_is_prefix = (w_byte_data == PS2_PREFIX_EXT) || (w_byte_data == PS2_PREFIX_BRK);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_byte_valid) begin
            if (w_is_ign)
                w_state_nxt = ST_IDLE;
            else if (w_byte_data == PS2_PREFIX_EXT)
                w_state_nxt = ST_EXT;
            else if (w_byte_data == PS2_PREFIX_BRK)
                w_state_nxt = ((r_state == ST_EXT) || (r_state == ST_EXT_BRK)) ? ST_EXT_BRK : ST_BRK;
            else
                w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_pressed_nxt = r_pressed;
        w_code_nxt    = r_code;
        if (w_byte_valid && !w_is_ign && !w_is_prefix) begin
            case (r_state)
                ST_IDLE, ST_EXT: begin
                    w_pressed_nxt = 1'b1;
                    w_code_nxt    = w_byte_data;
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (w_byte_data == r_code) w_pressed_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_pressed <= 1'b0;
            r_code    <= '0;
        end else begin
            r_pressed <= w_pressed_nxt;
            r_code    <= w_code_nxt;
        end
    end

    assign key_pressed      = r_pressed;
    assign key_pressed_code = r_code;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx with a shortened PS/2 bit period and timeout.
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int HALF       = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       drv_clk;
    logic       drv_data;
    wire        ps2_clk_w;
    wire        ps2_data_w;
    logic       key_pressed;
    logic [7:0] key_code;

    int vectors     = 0;
    int miscompares = 0;

    assign ps2_clk_w  = drv_clk;
    assign ps2_data_w = drv_data;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK              (clk),
        .reset            (rst_n),
        .PS2_CLK          (ps2_clk_w),
        .PS2_DATA         (ps2_data_w),
        .key_pressed      (key_pressed),
        .key_pressed_code (key_code)
    );

    function automatic logic [10:0] mkframe(input logic [7:0] d, input logic bad);
        return {1'b1, (~(^d)) ^ bad, d, 1'b0};
    endfunction

    task automatic send_bit(input logic b, input bit glitch);
        @(negedge clk);
        drv_data = b;
        if (glitch) begin
            repeat (10) @(negedge clk);
            drv_clk = 1'b0;
            repeat (FILTER_LEN - 1) @(negedge clk);
            drv_clk = 1'b1;
            repeat (HALF - 10 - (FILTER_LEN - 1)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        drv_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        drv_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n, input int glitch_idx);
        for (int i = 0; i < n; i++) send_bit(f[i], i == glitch_idx);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad);
        send_bits(mkframe(d, bad), 11, -1);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset;
        vectors++;
        if (key_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pressed: got %b want 0", key_pressed);
        end
        vectors++;
        if (key_code !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_code: got %h want 00", key_code);
        end
    endtask

    task automatic test_latency;
        logic [10:0] f;
        f = mkframe(8'h1D, 1'b0);
        send_bits(f, 10, -1);
        @(negedge clk);
        drv_data = 1'b1;
        repeat (HALF) @(negedge clk);
        drv_clk = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        vectors++;
        if (key_code !== 8'h00 || key_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got %h/%b want 00/0", key_code, key_pressed);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (key_code !== 8'h1D) begin
            miscompares++;
            $display("FAIL latency_code: got %h want 1d", key_code);
        end
        vectors++;
        if (key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_pressed: got %b want 1", key_pressed);
        end
        repeat (HALF) @(negedge clk);
        drv_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_break;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        vectors++;
        if (key_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL break_match_pressed: got %b want 0", key_pressed);
        end
        vectors++;
        if (key_code !== 8'h1D) begin
            miscompares++;
            $display("FAIL break_match_code: got %h want 1d", key_code);
        end
        send_byte(8'h1D, 1'b0);
        vectors++;
        if (key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL repress_pressed: got %b want 1", key_pressed);
        end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h23, 1'b0);
        vectors++;
        if (key_pressed !== 1'b1 || key_code !== 8'h1D) begin
            miscompares++;
            $display("FAIL break_other: got %h/%b want 1d/1", key_code, key_pressed);
        end
    endtask

    task automatic test_extended;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        vectors++;
        if (key_code !== 8'h75 || key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL ext_make: got %h/%b want 75/1", key_code, key_pressed);
        end
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        vectors++;
        if (key_code !== 8'h75 || key_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_break: got %h/%b want 75/0", key_code, key_pressed);
        end
    endtask

    task automatic test_ignored;
        send_byte(8'hF0, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h75, 1'b0);
        vectors++;
        if (key_code !== 8'h75 || key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_resets_fsm: got %h/%b want 75/1", key_code, key_pressed);
        end
    endtask

    task automatic test_parity;
        logic [7:0] exp_code;
`ifdef PS2_PARITY_CHECK_EN
        exp_code = 8'h75;
`else
        exp_code = 8'h23;
`endif
        send_byte(8'h23, 1'b1);
        vectors++;
        if (key_code !== exp_code || key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_parity: got %h/%b want %h/1", key_code, key_pressed, exp_code);
        end
    endtask

    task automatic test_timeout;
        send_bits(mkframe(8'h76, 1'b0), 5, -1);
        repeat (1000) @(negedge clk);
        send_byte(8'h76, 1'b0);
        vectors++;
        if (key_code !== 8'h76 || key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_recover: got %h/%b want 76/1", key_code, key_pressed);
        end
    endtask

    task automatic test_glitch;
        send_bits(mkframe(8'h1B, 1'b0), 11, 4);
        repeat (HALF) @(negedge clk);
        vectors++;
        if (key_code !== 8'h1B || key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_filter: got %h/%b want 1b/1", key_code, key_pressed);
        end
    endtask

    task automatic test_reset_midframe;
        send_bits(mkframe(8'h1C, 1'b0), 4, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (key_code !== 8'h00 || key_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midframe: got %h/%b want 00/0", key_code, key_pressed);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h1C, 1'b0);
        vectors++;
        if (key_code !== 8'h1C || key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset_frame: got %h/%b want 1c/1", key_code, key_pressed);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        drv_clk  = 1'b1;
        drv_data = 1'b1;
        repeat (5) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        test_latency;
        test_break;
        test_extended;
        test_ignored;
        test_parity;
        test_timeout;
        test_glitch;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
